// File: rtl/alu_issue_seq.sv
// Issue sequencer for the adiabatic ALU: buffers instructions and
// holds one decoded control word per Bennett cycle.
module alu_issue_seq #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instFlag,
  input  logic [WIDTH-1:0] clkpos,
  input  logic [WIDTH-1:0] clkneg,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  output logic             ALU_Control0,
  output logic             ALU_Control1,
  output logic             A_mux,
  output logic             B_mux0,
  output logic             B_mux1,
  output logic             Adder_Cin,
  output logic             SUB,
  output logic             STL,
  output logic             mux3_0,
  output logic             mux3_1,
  output logic [15:0]      instr_out,
  output logic             ALU_O_Fclkpos,
  output logic             A_Fclkpos,
  output logic             op_active,
  output logic             seq_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          flag_q;
  logic          rise;
  logic          peak;
  logic          push;
  logic          pop;
  logic [15:0]   head;
  logic [3:0]    op;
  logic [9:0]    dec;
  logic          legal;
  logic [9:0]    ctrl_q;
  logic          fclk_q;
  logic          peak_seen;

  assign rise     = instFlag & ~flag_q;
  assign peak     = (clkpos == '1) && (clkneg == '0);
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = rise & (count != '0);
  assign head     = mem[rd_ptr];
  assign op       = head[15:12];

  // opcode to {ctrl1,ctrl0,a,b1,b0,cin,sub,stl,m1,m0}
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    unique case (op)
      4'd0: dec = 10'b00_0_00_0_0_0_00;
      4'd1: dec = 10'b01_1_11_0_0_0_00;
      4'd2: dec = 10'b01_1_11_1_1_0_00;
      4'd3: dec = 10'b01_1_11_1_1_1_01;
      4'd4: dec = 10'b00_1_11_0_0_0_00;
      4'd5: dec = 10'b10_1_11_0_0_0_00;
      4'd6: dec = 10'b01_1_01_0_0_0_00;
      4'd7: dec = 10'b01_0_00_1_0_0_00;
      default: legal = 1'b0;
    endcase
  end

  // fifo storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // fifo pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // boundary edge detect; starts high so no rise at release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flag_q <= 1'b1;
    else        flag_q <= instFlag;
  end

  // control word held for a full Bennett cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= '0;
      instr_out <= '0;
      op_active <= 1'b0;
    end else if (rise) begin
      if (pop && legal) begin
        ctrl_q    <= dec;
        instr_out <= head;
        op_active <= (op != 4'd0);
      end else begin
        ctrl_q    <= '0;
        instr_out <= '0;
        op_active <= 1'b0;
      end
    end
  end

  // slow-clock pulse and per-cycle peak tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fclk_q    <= 1'b0;
      peak_seen <= 1'b0;
    end else begin
      fclk_q <= peak & op_active;
      if (rise)                  peak_seen <= 1'b0;
      else if (peak & op_active) peak_seen <= 1'b1;
    end
  end

  // sticky error: illegal opcode or active op without a peak
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_err <= 1'b0;
    end else if (rise) begin
      if ((pop && !legal) || (op_active && !peak_seen))
        seq_err <= 1'b1;
    end
  end

  assign {ALU_Control1, ALU_Control0, A_mux, B_mux1, B_mux0,
          Adder_Cin, SUB, STL, mux3_1, mux3_0} = ctrl_q;
  assign ALU_O_Fclkpos = fclk_q;
  assign A_Fclkpos     = fclk_q;

endmodule
